// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports plus the shared-memory side of the arbiter.
// The arbiter connects through the slave modport; requesters and memory model use master.
interface mem_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_lock;
   logic        m0_gnt;
   logic        m0_rvalid;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_lock;
   logic        m1_gnt;
   logic        m1_rvalid;
   logic [31:0] m1_rdata;

   logic [31:0] mem_address;
   logic [31:0] mem_data_out;
   logic        mem_we;
   logic [31:0] mem_data_in;

   logic        owner;
   logic        lock_err;

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
      output mem_data_in,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_address, mem_data_out, mem_we,
      input  owner, lock_err
   );

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
      input  mem_data_in,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_address, mem_data_out, mem_we,
      output owner, lock_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory: round-robin grants, optional
// read-modify-write lock per requester with an idle-cycle timeout.
module mem_arbiter #(
   parameter int LOCK_MAX = 16
) (
   input  logic         clk,
   input  logic         resetn,
   mem_arbiter_if.slave bus
);

   localparam int TW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t          state;
   logic            req_we;
   logic            req_lock;
   logic [31:0]     req_addr;
   logic [31:0]     req_wdata;
   logic            owner_q;
   logic            prio;
   logic            lock_active;
   logic [TW-1:0]   lock_timer;
   logic            lock_err_q;
   logic            m0_rvalid_q;
   logic            m1_rvalid_q;

   logic            gnt0;
   logic            gnt1;
   logic            accept;
   logic            owner_req;
   logic            lock_expired;
   logic            sel_we;
   logic            sel_lock;
   logic [31:0]     sel_addr;
   logic [31:0]     sel_wdata;

   assign owner_req    = owner_q ? bus.m1_req : bus.m0_req;
   assign lock_expired = lock_active && (lock_timer == TW'(LOCK_MAX));

   // The cycle in which lock_err is visible is a dead cycle: the lock is being
   // dropped, so nobody is granted and normal arbitration resumes afterwards.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (resetn && state == IDLE && !lock_expired) begin
         if (lock_active) begin
            gnt0 = !owner_q && bus.m0_req;
            gnt1 = owner_q && bus.m1_req;
         end else if (bus.m0_req && bus.m1_req) begin
            gnt0 = !prio;
            gnt1 = prio;
         end else begin
            gnt0 = bus.m0_req;
            gnt1 = bus.m1_req;
         end
      end
   end

   assign accept    = gnt0 | gnt1;
   assign sel_we    = gnt1 ? bus.m1_we    : bus.m0_we;
   assign sel_lock  = gnt1 ? bus.m1_lock  : bus.m0_lock;
   assign sel_addr  = gnt1 ? bus.m1_addr  : bus.m0_addr;
   assign sel_wdata = gnt1 ? bus.m1_wdata : bus.m0_wdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         req_we      <= 1'b0;
         req_lock    <= 1'b0;
         req_addr    <= '0;
         req_wdata   <= '0;
         owner_q     <= 1'b0;
         prio        <= 1'b0;
         lock_active <= 1'b0;
         lock_timer  <= '0;
         lock_err_q  <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
      end else begin
         lock_err_q  <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= ISSUE;
                  req_we     <= sel_we;
                  req_lock   <= sel_lock;
                  req_addr   <= sel_addr;
                  req_wdata  <= sel_wdata;
                  owner_q    <= gnt1;
                  prio       <= ~gnt1;
                  lock_timer <= '0;
                  if (sel_lock) begin
                     lock_active <= 1'b1;
                  end
               end else if (lock_expired) begin
                  lock_active <= 1'b0;
                  lock_timer  <= '0;
               end else if (lock_active && !owner_req) begin
                  if (lock_timer == TW'(LOCK_MAX - 1)) begin
                     lock_err_q <= 1'b1;
                  end
                  lock_timer <= lock_timer + TW'(1);
               end
            end
            ISSUE: begin
               state       <= RESP;
               m0_rvalid_q <= !owner_q;
               m1_rvalid_q <= owner_q;
            end
            RESP: begin
               // An owner access without lock releases the port once it completes.
               state       <= IDLE;
               lock_active <= req_lock;
               lock_timer  <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.m0_gnt       = gnt0;
   assign bus.m1_gnt       = gnt1;
   assign bus.m0_rvalid    = m0_rvalid_q;
   assign bus.m1_rvalid    = m1_rvalid_q;
   assign bus.m0_rdata     = m0_rvalid_q ? bus.mem_data_in : 32'd0;
   assign bus.m1_rdata     = m1_rvalid_q ? bus.mem_data_in : 32'd0;
   assign bus.mem_address  = req_addr;
   assign bus.mem_data_out = req_wdata;
   assign bus.mem_we       = (state == ISSUE) && req_we;
   assign bus.owner        = owner_q;
   assign bus.lock_err     = lock_err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LOCK_MAX, default 16, maximum number of IDLE cycles a held lock survives without an owner request.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: resetn  in  1  reset, asynchronous and active-low.
REQ-004 Port: mN_req  in  1  (N=0,1) requester N access request; held until granted.
REQ-005 Port: mN_we  in  1  1 = write, 0 = read; sampled at grant.
REQ-006 Port: mN_addr  in  32  byte address; sampled at grant.
REQ-007 Port: mN_wdata  in  32  write data; sampled at grant.
REQ-008 Port: mN_lock  in  1  keep port ownership after this access (read-modify-write); sampled at grant.
REQ-009 Port: mN_gnt  out  1  request accepted this cycle.
REQ-010 Port: mN_rvalid  out  1  one-cycle completion pulse (read data valid / write ack).
REQ-011 Port: mN_rdata  out  32  read data; valid only while mN_rvalid=1.
REQ-012 Port: mem_address  out  32  address to the shared memory.
REQ-013 Port: mem_data_out  out  32  write data to memory.
REQ-014 Port: mem_we  out  1  memory write enable.
REQ-015 Port: mem_data_in  in  32  memory read data; valid the cycle after the address is presented.
REQ-016 Port: owner  out  1  index of the requester currently granted or holding the lock.
REQ-017 Port: lock_err  out  1  one-cycle pulse when a lock is dropped by timeout.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE and RESP, with transitions IDLE->ISSUE on grant, ISSUE->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-019 mN_gnt SHALL be combinational and asserted only in IDLE, to at most one requester per cycle; the accept cycle is T.
REQ-020 On accept, the block SHALL register we/addr/wdata/lock and the owner index.
REQ-021 In ISSUE (T+1), mem_address, mem_data_out and mem_we SHALL be driven from the registered values; mem_we=0 in every other state.
REQ-022 In RESP (T+2), the owner's mN_rvalid SHALL be 1 and mN_rdata SHALL equal mem_data_in; for writes, rvalid is still pulsed and rdata is don't-care.
REQ-023 The non-owner's rvalid SHALL be 0; fixed latency accept->rvalid = 2 cycles; maximum throughput is one access per 3 cycles.
REQ-024 Outside ISSUE, mem_address and mem_data_out SHALL hold their last values.
REQ-025 With no lock active, if only one requester requests, that requester SHALL be granted.
REQ-026 With no lock active and both requesting, the grant SHALL go to the requester indicated by a round-robin pointer prio.
REQ-027 After every grant, prio SHALL be set to the other requester.
REQ-028 A grant with mN_lock=1 SHALL set the lock for owner N.
REQ-029 While the lock is set, only owner N SHALL be grantable; the other requester waits regardless of prio.
REQ-030 A granted owner access with mN_lock=0 SHALL clear the lock after that access completes.
REQ-031 The lock timer SHALL count IDLE cycles while the lock is set and owner mN_req=0, and SHALL reset to 0 on any owner grant.
REQ-032 When the lock timer reaches LOCK_MAX, the lock SHALL clear and lock_err SHALL pulse for 1 cycle; arbitration is normal from the next cycle.
REQ-033 A request dropped before grant SHALL be ignored; the block SHALL NOT latch pending requests.
REQ-034 Simultaneous new requests during ISSUE/RESP SHALL wait; they are arbitrated in the next IDLE.
REQ-035 owner SHALL hold the last granted index when idle and unlocked.

Reset
REQ-036 resetn=0 SHALL immediately (asynchronously) force state IDLE, with mem_we=0, all gnt/rvalid=0, lock cleared, timer=0, prio=0, owner=0, lock_err=0, mem_address=0, mem_data_out=0, registered request fields=0.
REQ-037 Reset mid-transaction (ISSUE or RESP) SHALL abort it with no rvalid pulse; after release, the first accept is possible in the first IDLE cycle.

Verification
REQ-038 Single read: m0 requests read of 0x100, mem_data_in=0xDEADBEEF at T+2 -> m0_gnt at T, mem_address=0x100 with mem_we=0 at T+1, m0_rvalid=1 and m0_rdata=0xDEADBEEF at T+2.
REQ-039 Contention: m0 and m1 both request continuously from reset -> grants alternate m0, m1, m0, m1 at T, T+3, T+6, T+9.
REQ-040 Locked RMW: m0 reads 0x20 with lock=1 while m1 requests -> m0 writes 0x20 (lock=0) next; m1 is granted only after m0's write rvalid.
REQ-041 Lock timeout: LOCK_MAX=4, m0 grabs lock then drops req, m1 requesting -> lock_err pulses after 4 IDLE cycles, and m1_gnt follows in the next cycle.
REQ-042 Reset mid-ISSUE of an m1 write of 0x55 to 0x40 -> mem_we falls at once, no m1_rvalid, and all outputs take their reset values.
REQ-043 Write ack: m1 writes 0x12345678 to 0x8 -> mem_we=1 with matching address/data for exactly one cycle, and m1_rvalid pulses at T+2.
